led_pattern_gen: RTL
====================

Name: led_pattern_gen

Overview:
- Parametrised successor to the single-mode LED blinker.
- Drives LED_NUMBER board LEDs from a runtime-selectable pattern: blink, chase, bounce or PWM breathe.
- Timebase comes from an internal prescaler derived from CLK_HZ.
- Sits at top level between the board clock and the LED pins; output polarity is set by parameter.

Parameters:
- CLK_HZ, 27000000, input clock frequency in Hz.
- STEP_HZ, 2, pattern step rate for blink/chase/bounce; DIV = CLK_HZ/STEP_HZ, integer division, must be >= 2.
- LED_NUMBER, 6, number of LED channels, >= 1.
- PWM_BITS, 8, breathe PWM resolution; PWM_MAX = 2^PWM_BITS-1.
- BREATHE_DIV, 52734, clocks per breathe duty step, >= 1.
- ACTIVE_LOW, 1, 1 = LED lit when pin is 0.

Ports:
- clk  in  1  board clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = run; 0 = freeze prescalers and pattern state.
- mode  in  2  0 BLINK, 1 CHASE, 2 BOUNCE, 3 BREATHE.
- leds  out  LED_NUMBER  LED pins, registered.
- step_pulse  out  1  one-cycle strobe on each pattern step, registered.

Behaviour:
- Reset (rst=1 at an edge), next cycle:
  - prescaler counts = 0, mode_q = mode.
  - blink value = 0, chase/bounce position = 0, bounce dir = up.
  - duty = 0, duty dir = up, pwm_cnt = 0.
  - leds = all off (all 1 if ACTIVE_LOW, else all 0); step_pulse = 0.
  - rst wins over every other event.
- Step prescaler: step_cnt counts 0..DIV-1 while enable=1 and wraps to 0. step_tick = enable & (step_cnt == DIV-1).
- step_pulse is step_tick registered, i.e. 1 cycle after the wrap.
- Fine prescaler: fine_cnt counts 0..BREATHE_DIV-1 the same way. fine_tick is its wrap. Both prescalers run in all modes.
- pwm_cnt: free-running PWM_BITS counter, increments every cycle while enable=1, wraps at PWM_MAX.
- Pattern state updates on the edge where its tick is high:
  - BLINK: value ^= 1; all LEDs lit when value = 1.
  - CHASE: exactly one LED lit at pos; pos increments, wraps LED_NUMBER-1 -> 0.
  - BOUNCE: one LED lit at pos.
    - dir up: pos+1; on reaching LED_NUMBER-1, dir flips to down.
    - dir down: pos-1; on reaching 0, dir flips to up.
    - Endpoints are lit for one step only, giving a sequence for 4 LEDs of 0,1,2,3,2,1,0,1...
    - LED_NUMBER = 1: pos stays 0.
  - BREATHE (uses fine_tick):
    - dir up: duty+1; on reaching PWM_MAX, dir flips to down.
    - dir down: duty-1; on reaching 0, dir flips to up.
    - All LEDs lit when pwm_cnt < duty. duty = 0 means always off; duty = PWM_MAX means lit PWM_MAX of 2^PWM_BITS cycles.
- Mode change: when mode != mode_q, then in that edge:
  - mode_q <= mode.
  - all pattern state and both prescalers return to their reset values.
  - no step is taken.
  - The new pattern starts from its initial state; first step occurs DIV (or BREATHE_DIV) cycles later.
- enable = 0: all counters and state hold, leds hold their last value, step_pulse = 0. On re-enable, counting resumes from the held values.
- leds = registered pattern vector, inverted when ACTIVE_LOW = 1. Latency is 1 cycle from a state change to the pin.
- Widths: counters sized with $clog2(max value + 1). No arithmetic overflow is permitted: the wrap compares come before the increments.

Decomposition:
- Shared package led_pattern_pkg holds:
  - mode enum (MODE_BLINK/CHASE/BOUNCE/BREATHE).
  - localparam function for counter width.
  - LED-off constant derivation helper.
- One sub-module, tick_divider (parameter DIV; ports clk, rst, clr, en, tick), instantiated twice: step and fine.
- Pattern logic and output mux stay in led_pattern_gen.

Test Plan (CLK_HZ=20, STEP_HZ=2 so DIV=10; LED_NUMBER=4; PWM_BITS=3; BREATHE_DIV=2; ACTIVE_LOW=1):
- Reset / BLINK:
  - Stimulus: rst 3 cycles, then mode=0, enable=1.
  - Required: leds=4'b1111 through reset.
  - Required: leds=4'b0000 at cycle 11 after release, 4'b1111 at cycle 21.
  - Required: step_pulse high cycles 11, 21.
- CHASE:
  - Stimulus: mode=1, run 50 cycles.
  - Required: lit-LED index sequence 0,1,2,3,0 every 10 cycles (leds 1110,1101,1011,0111,1110).
- BOUNCE:
  - Stimulus: mode=2, run 80 cycles.
  - Required: index sequence 0,1,2,3,2,1,0,1.
  - Required: position 3 held exactly one step.
- BREATHE:
  - Stimulus: mode=3.
  - Required: duty sequence 0..7..0 with one change per 2 cycles.
  - Required: with duty=3, leds=0000 for pwm_cnt 0..2, 1111 for 3..7.
  - Required: duty=0 means leds stay 1111.
- Enable freeze:
  - Stimulus: in CHASE, drop enable mid-step at step_cnt=5 for 30 cycles, then raise it.
  - Required: leds unchanged and step_pulse=0 during freeze.
  - Required: next step arrives 5 cycles after re-enable.
- Mode change + mid-run reset:
  - Stimulus: switch 1->2 at step_cnt=7.
  - Required: pos=0, dir up, first BOUNCE step 10 cycles later.
  - Stimulus: then assert rst mid-BREATHE with duty=5.
  - Required: leds=1111 and duty=0 the next cycle.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared types and helpers for the LED pattern generator
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Pin level that leaves an LED dark for the given polarity.
  function automatic logic led_off_bit(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/led_pattern_gen_tick_divider.sv
// rtl/led_pattern_gen_tick_divider.sv - wrap-around prescaler producing a one-cycle tick
module tick_divider
  import led_pattern_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = cnt_width(DIV - 1);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count 0..DIV-1 while enabled; wrap is tested before incrementing.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - runtime-selectable blink/chase/bounce/breathe LED driver
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int CLK_HZ      = 27000000,
  parameter int STEP_HZ     = 2,
  parameter int LED_NUMBER  = 6,
  parameter int PWM_BITS    = 8,
  parameter int BREATHE_DIV = 52734,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  output logic [LED_NUMBER-1:0] leds,
  output logic                  step_pulse
);

  localparam int DIV   = CLK_HZ / STEP_HZ;
  localparam int POS_W = cnt_width(LED_NUMBER - 1);

  localparam logic [POS_W-1:0]    LAST_POS = POS_W'(LED_NUMBER - 1);
  localparam logic [POS_W-1:0]    PEN_POS  = POS_W'((LED_NUMBER > 1) ? LED_NUMBER - 2 : 0);
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
  localparam logic [PWM_BITS-1:0] PWM_PEN  = PWM_MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [POS_W-1:0]    POS_ONE  = POS_W'(1);
  localparam logic [LED_NUMBER-1:0] LED_OFF = {LED_NUMBER{led_off_bit(ACTIVE_LOW)}};

  mode_e                 mode_q;
  logic                  mode_change;
  logic                  step_tick;
  logic                  fine_tick;
  logic                  blink_val;
  logic [POS_W-1:0]      pos;
  logic                  pos_up;
  logic [PWM_BITS-1:0]   duty;
  logic                  duty_up;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [LED_NUMBER-1:0] pattern;

  assign mode_change = (mode != mode_q);

  tick_divider #(.DIV(DIV)) u_step_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (mode_change),
    .en   (enable),
    .tick (step_tick)
  );

  tick_divider #(.DIV(BREATHE_DIV)) u_fine_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (mode_change),
    .en   (enable),
    .tick (fine_tick)
  );

  // Pattern state: reset and mode change both restart the selected pattern without stepping.
  always_ff @(posedge clk) begin
    if (rst || mode_change) begin
      mode_q    <= mode_e'(mode);
      blink_val <= 1'b0;
      pos       <= '0;
      pos_up    <= 1'b1;
      duty      <= '0;
      duty_up   <= 1'b1;
      pwm_cnt   <= '0;
    end else if (enable) begin
      if (pwm_cnt == PWM_MAX) pwm_cnt <= '0;
      else                    pwm_cnt <= pwm_cnt + 1'b1;

      if (step_tick) begin
        case (mode_q)
          MODE_BLINK: blink_val <= ~blink_val;
          MODE_CHASE: begin
            if (pos == LAST_POS) pos <= '0;
            else                 pos <= pos + 1'b1;
          end
          MODE_BOUNCE: begin
            if (LED_NUMBER > 1) begin
              if (pos_up) begin
                pos <= pos + 1'b1;
                if (pos == PEN_POS) pos_up <= 1'b0;
              end else begin
                pos <= pos - 1'b1;
                if (pos == POS_ONE) pos_up <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end

      if (fine_tick && (mode_q == MODE_BREATHE)) begin
        if (duty_up) begin
          duty <= duty + 1'b1;
          if (duty == PWM_PEN) duty_up <= 1'b0;
        end else begin
          duty <= duty - 1'b1;
          if (duty == PWM_ONE) duty_up <= 1'b1;
        end
      end
    end
  end

  // Lit-LED vector (1 = lit) for the current mode and state.
  always_comb begin
    pattern = '0;
    case (mode_q)
      MODE_BLINK:   pattern = blink_val ? '1 : '0;
      MODE_CHASE,
      MODE_BOUNCE:  pattern = LED_NUMBER'(1) << pos;
      MODE_BREATHE: pattern = (pwm_cnt < duty) ? '1 : '0;
      default:      pattern = '0;
    endcase
  end

  // Registered pins and step strobe; pins hold while the generator is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      leds       <= LED_OFF;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= step_tick && !mode_change;
      if (enable) leds <= (ACTIVE_LOW != 0) ? ~pattern : pattern;
    end
  end

endmodule
